// File: rtl/mult_acc_pipe.sv
// rtl/mult_acc_pipe.sv - pipelined signed/unsigned multiply and saturating multiply-accumulate
module mult_acc_pipe #(
  parameter  int A_WIDTH   = 8,
  parameter  int B_WIDTH   = 8,
  parameter  int LATENCY   = 3,
  localparam int OUT_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   input_1,
  input  logic [B_WIDTH-1:0]   input_2,
  input  logic [1:0]           in_mode,
  input  logic                 in_first,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] output_3,
  output logic                 out_ovf
);

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance & ~rst;

  // Operands are extended to the full result width so a single OUT_WIDTH
  // multiply is exact for both interpretations; the true product always fits.
  logic [OUT_WIDTH-1:0] a_ext, b_ext, product;
  assign a_ext   = {{B_WIDTH{in_mode[0] & input_1[A_WIDTH-1]}}, input_1};
  assign b_ext   = {{A_WIDTH{in_mode[0] & input_2[B_WIDTH-1]}}, input_2};
  assign product = a_ext * b_ext;

  logic [LATENCY-1:0]   s_valid;
  logic [LATENCY-1:0]   s_first;
  logic [1:0]           s_mode [LATENCY];
  logic [OUT_WIDTH-1:0] s_prod [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= '0;
    end else if (advance) begin
      s_valid[0] <= in_valid;
      s_first[0] <= in_first;
      s_mode[0]  <= in_mode;
      s_prod[0]  <= product;
      for (int k = 1; k < LATENCY; k++) begin
        s_valid[k] <= s_valid[k-1];
        s_first[k] <= s_first[k-1];
        s_mode[k]  <= s_mode[k-1];
        s_prod[k]  <= s_prod[k-1];
      end
    end
  end

  logic                 f_valid, f_first;
  logic [1:0]           f_mode;
  logic [OUT_WIDTH-1:0] f_prod;
  assign f_valid = s_valid[LATENCY-1];
  assign f_first = s_first[LATENCY-1];
  assign f_mode  = s_mode[LATENCY-1];
  assign f_prod  = s_prod[LATENCY-1];

  logic [OUT_WIDTH-1:0] acc, base;
  logic [OUT_WIDTH:0]   sum_u, sum_s;
  assign base  = f_first ? '0 : acc;
  assign sum_u = {1'b0, base} + {1'b0, f_prod};
  assign sum_s = {base[OUT_WIDTH-1], base} + {f_prod[OUT_WIDTH-1], f_prod};

  logic [OUT_WIDTH-1:0] res;
  logic                 res_ovf;

  always_comb begin
    res     = f_prod;
    res_ovf = 1'b0;
    if (f_mode[1]) begin
      if (f_mode[0]) begin
        // Signed overflow shows as disagreement between the carry-out and sign bits.
        if (sum_s[OUT_WIDTH] != sum_s[OUT_WIDTH-1]) begin
          res_ovf = 1'b1;
          res     = sum_s[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                     : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else begin
          res = sum_s[OUT_WIDTH-1:0];
        end
      end else begin
        if (sum_u[OUT_WIDTH]) begin
          res_ovf = 1'b1;
          res     = '1;
        end else begin
          res = sum_u[OUT_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      output_3  <= '0;
      out_ovf   <= 1'b0;
      acc       <= '0;
    end else if (advance) begin
      out_valid <= f_valid;
      if (f_valid) begin
        output_3 <= res;
        out_ovf  <= res_ovf;
        if (f_mode[1]) acc <= res;
      end
    end
  end

endmodule

// File: tb/tb_mult_acc_pipe.sv
// tb/tb_mult_acc_pipe.sv - directed self-checking bench for mult_acc_pipe
module tb_mult_acc_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  input_1;
  logic [7:0]  input_2;
  logic [1:0]  in_mode;
  logic        in_first;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] output_3;
  logic        out_ovf;

  int tests_run = 0;
  int fails     = 0;

  logic [15:0] res_q[$];
  logic        ovf_q[$];

  mult_acc_pipe #(.A_WIDTH(8), .B_WIDTH(8), .LATENCY(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .input_1(input_1), .input_2(input_2),
    .in_mode(in_mode), .in_first(in_first),
    .out_valid(out_valid), .out_ready(out_ready),
    .output_3(output_3), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every result that the next rising edge will consume.
  always @(negedge clk) begin
    if (out_valid && out_ready && !rst) begin
      res_q.push_back(output_3);
      ovf_q.push_back(out_ovf);
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] m, input logic f);
    int   cyc;
    logic got;
    input_1  = a;
    input_2  = b;
    in_mode  = m;
    in_first = f;
    in_valid = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (!got) begin
      fails++;
      $display("FAIL send_accept: in_ready never high for %0h*%0h", a, b);
    end
  endtask

  task automatic wait_results(input int n);
    int cyc;
    cyc = 0;
    while (res_q.size() < n && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    tests_run++;
    if (res_q.size() < n) begin
      fails++;
      $display("FAIL result_timeout: got %0d results, need %0d", res_q.size(), n);
    end
  endtask

  task automatic check_results(input string name, input logic [15:0] exp_r[],
                               input logic exp_o[]);
    tests_run++;
    if (res_q.size() != exp_r.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d results, need %0d", name, res_q.size(), exp_r.size());
    end
    for (int i = 0; i < exp_r.size() && i < res_q.size(); i++) begin
      tests_run++;
      if (res_q[i] !== exp_r[i] || ovf_q[i] !== exp_o[i]) begin
        fails++;
        $display("FAIL %s[%0d]: got %h ovf %b, need %h ovf %b",
                 name, i, res_q[i], ovf_q[i], exp_r[i], exp_o[i]);
      end
    end
    res_q.delete();
    ovf_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || output_3 !== 16'h0 || out_ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: in_ready %b out_valid %b output_3 %h ovf %b, need 0 0 0000 0",
               in_ready, out_valid, output_3, out_ovf);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b, need 1", in_ready);
    end
  endtask

  task automatic test_latency;
    logic exp_v;
    out_ready = 1'b1;
    res_q.delete();
    ovf_q.delete();
    send(8'd200, 8'd200, 2'b00, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      exp_v = (k == 3);
      tests_run++;
      if (out_valid !== exp_v) begin
        fails++;
        $display("FAIL latency_valid_edge%0d: got %b, need %b", k, out_valid, exp_v);
      end
    end
    tests_run++;
    if (output_3 !== 16'h9C40 || out_ovf !== 1'b0) begin
      fails++;
      $display("FAIL latency_result: got %h ovf %b, need 9c40 ovf 0", output_3, out_ovf);
    end
    @(posedge clk);
    #1;
    res_q.delete();
    ovf_q.delete();
  endtask

  task automatic test_signed;
    send(8'hFF, 8'h05, 2'b01, 1'b0);
    send(8'hFF, 8'h05, 2'b00, 1'b0);
    send(8'h80, 8'h80, 2'b01, 1'b0);
    wait_results(3);
    check_results("signedness", '{16'hFFFB, 16'h04FB, 16'h4000}, '{1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_unsigned_acc;
    send(8'd255, 8'd255, 2'b10, 1'b1);
    send(8'd255, 8'd255, 2'b10, 1'b0);
    send(8'd2,   8'd3,   2'b10, 1'b1);
    wait_results(3);
    check_results("unsigned_acc", '{16'hFE01, 16'hFFFF, 16'h0006}, '{1'b0, 1'b1, 1'b0});
  endtask

  task automatic test_signed_acc;
    send(8'd127, 8'd127, 2'b11, 1'b1);
    send(8'd127, 8'd127, 2'b11, 1'b0);
    send(8'd127, 8'd127, 2'b11, 1'b0);
    send(8'h80,  8'd127, 2'b11, 1'b0);
    wait_results(4);
    // 0x7FFF + (-128*127) = 32767 - 16256 = 16511
    check_results("signed_acc", '{16'h3F01, 16'h7E02, 16'h7FFF, 16'h407F},
                  '{1'b0, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic test_back_to_back;
    logic [15:0] held;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 1; i <= 6; i++) send(8'(i), 8'(i), 2'b00, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        #1;
        held = output_3;
        tests_run++;
        if (out_valid !== 1'b1 || held !== 16'd1) begin
          fails++;
          $display("FAIL stall_start: out_valid %b output_3 %h, need 1 0001", out_valid, held);
        end
        for (int c = 0; c < 4; c++) begin
          tests_run++;
          if (in_ready !== !out_valid) begin
            fails++;
            $display("FAIL stall_in_ready[%0d]: got %b, need %b", c, in_ready, !out_valid);
          end
          tests_run++;
          if (output_3 !== held) begin
            fails++;
            $display("FAIL stall_hold[%0d]: got %h, need %h", c, output_3, held);
          end
          @(posedge clk);
          #2;
        end
        out_ready = 1'b1;
      end
    join
    wait_results(6);
    check_results("back_to_back", '{16'd1, 16'd4, 16'd9, 16'd16, 16'd25, 16'd36},
                  '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_reset_midstream;
    int seen;
    out_ready = 1'b1;
    send(8'h14, 8'hE9, 2'b10, 1'b1);
    wait_results(1);
    check_results("acc_preload", '{16'h1234}, '{1'b0});
    send(8'd2, 8'd2, 2'b00, 1'b0);
    send(8'd3, 8'd3, 2'b00, 1'b0);
    send(8'd4, 8'd4, 2'b10, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || output_3 !== 16'h0) begin
      fails++;
      $display("FAIL midreset_state: out_valid %b output_3 %h, need 0 0000", out_valid, output_3);
    end
    res_q.delete();
    ovf_q.delete();
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      fails++;
      $display("FAIL midreset_flush: got %0d stale results, need 0", seen);
    end
    send(8'd1, 8'd1, 2'b10, 1'b0);
    wait_results(1);
    check_results("midreset_acc", '{16'h0001}, '{1'b0});
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    input_1   = '0;
    input_2   = '0;
    in_mode   = '0;
    in_first  = 1'b0;
    out_ready = 1'b1;
    test_reset;
    test_latency;
    test_signed;
    test_unsigned_acc;
    test_signed_acc;
    test_back_to_back;
    test_reset_midstream;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
